// File: rtl/aes_cipher_core_ctrl.sv
// AES-256 cipher-core initiator: takes a command (direction, key, block count),
// streams 128-bit blocks through the core and returns results on dout.
// Keeps the decryption key schedule cached across commands that share a key.
module aes_cipher_core_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic             cmd_decrypt_i,
  input  logic [255:0]     cmd_key_i,
  input  logic [CNT_W-1:0] cmd_nblocks_i,
  input  logic             din_valid_i,
  output logic             din_ready_o,
  input  logic [127:0]     din_data_i,
  output logic             dout_valid_o,
  input  logic             dout_ready_i,
  output logic [127:0]     dout_data_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic             core_in_valid_o,
  input  logic             core_in_ready_i,
  input  logic             core_out_valid_i,
  output logic             core_out_ready_o,
  output logic [1:0]       core_op_o,
  output logic [2:0]       core_key_len_o,
  output logic             core_crypt_o,
  output logic             core_dec_key_gen_o,
  output logic             core_prng_reseed_o,
  output logic [127:0]     core_state_init_o,
  output logic [255:0]     core_key_init_o,
  input  logic [127:0]     core_state_i,
  input  logic             core_alert_i
);

  localparam logic [1:0] CIPH_FWD = 2'b01;
  localparam logic [1:0] CIPH_INV = 2'b10;

  typedef enum logic [2:0] {
    IDLE, KEYGEN_REQ, KEYGEN_WAIT, LOAD, BLK_REQ, BLK_WAIT, DRAIN, ERROR
  } state_e;

  state_e             state_reg, state_next;
  logic [255:0]       key_reg;
  logic               dir_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic               dec_key_ok_reg;
  logic [127:0]       blk_reg;
  logic [127:0]       dout_reg;
  logic               dout_valid_reg;
  logic               busy_reg;
  logic               done_reg;
  logic               err_reg;

  logic key_same;
  logic cmd_fire;
  logic din_fire;
  logic dout_fire;
  logic keygen_done;
  logic blk_out_fire;

  assign key_same     = (cmd_key_i == key_reg);
  assign cmd_fire     = cmd_valid_i && cmd_ready_o;
  assign din_fire     = din_valid_i && din_ready_o;
  assign dout_fire    = dout_valid_reg && dout_ready_i;
  assign keygen_done  = (state_reg == KEYGEN_WAIT) && core_out_valid_i;
  assign blk_out_fire = (state_reg == BLK_WAIT) && core_out_valid_i && core_out_ready_o;

  assign dout_valid_o       = dout_valid_reg;
  assign dout_data_o        = dout_reg;
  assign busy_o             = busy_reg;
  assign done_o             = done_reg;
  assign err_o              = err_reg;
  assign core_key_len_o     = 3'b100;
  assign core_prng_reseed_o = 1'b0;
  assign core_state_init_o  = blk_reg;
  assign core_key_init_o    = key_reg;

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_reg <= IDLE;
    else         state_reg <= state_next;
  end

  // Next-state logic and state-decoded handshake/control outputs
  always_comb begin
    state_next         = state_reg;
    cmd_ready_o        = 1'b0;
    din_ready_o        = 1'b0;
    core_in_valid_o    = 1'b0;
    core_out_ready_o   = 1'b0;
    core_crypt_o       = 1'b0;
    core_dec_key_gen_o = 1'b0;
    core_op_o          = CIPH_FWD;
    case (state_reg)
      IDLE: begin
        cmd_ready_o = !dout_valid_reg;
        if (cmd_valid_i && !dout_valid_reg) begin
          if (cmd_nblocks_i == '0)                              state_next = IDLE;
          else if (cmd_decrypt_i && !(dec_key_ok_reg && key_same)) state_next = KEYGEN_REQ;
          else                                                  state_next = LOAD;
        end
      end
      KEYGEN_REQ: begin
        // Key-schedule generation always runs the core in the forward direction
        core_in_valid_o    = 1'b1;
        core_dec_key_gen_o = 1'b1;
        if (core_in_ready_i) state_next = KEYGEN_WAIT;
      end
      KEYGEN_WAIT: begin
        core_out_ready_o = 1'b1;
        if (core_out_valid_i) state_next = LOAD;
      end
      LOAD: begin
        din_ready_o = 1'b1;
        if (din_valid_i) state_next = BLK_REQ;
      end
      BLK_REQ: begin
        core_in_valid_o = 1'b1;
        core_crypt_o    = 1'b1;
        core_op_o       = dir_reg ? CIPH_INV : CIPH_FWD;
        if (core_in_ready_i) state_next = BLK_WAIT;
      end
      BLK_WAIT: begin
        // Only pull a result when the single dout slot is free
        core_out_ready_o = !dout_valid_reg;
        if (core_out_valid_i && !dout_valid_reg)
          state_next = (cnt_reg == CNT_W'(1)) ? DRAIN : LOAD;
      end
      DRAIN: begin
        if (dout_valid_reg && dout_ready_i) state_next = IDLE;
      end
      ERROR:   state_next = ERROR;
      default: state_next = IDLE;
    endcase
    if (core_alert_i) state_next = ERROR;
  end

  // Command latch, block/result registers, counter, key-cache flag and status
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      key_reg        <= '0;
      dir_reg        <= 1'b0;
      cnt_reg        <= '0;
      dec_key_ok_reg <= 1'b0;
      blk_reg        <= '0;
      dout_reg       <= '0;
      dout_valid_reg <= 1'b0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
      err_reg        <= 1'b0;
    end else if (core_alert_i || state_reg == ERROR) begin
      // Fatal: drop everything in flight and stay quiet until reset
      err_reg        <= 1'b1;
      dec_key_ok_reg <= 1'b0;
      dout_valid_reg <= 1'b0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (cmd_fire) begin
        key_reg  <= cmd_key_i;
        dir_reg  <= cmd_decrypt_i;
        cnt_reg  <= cmd_nblocks_i;
        busy_reg <= (cmd_nblocks_i != '0);
        done_reg <= (cmd_nblocks_i == '0);
        if (!key_same) dec_key_ok_reg <= 1'b0;
      end
      if (keygen_done) dec_key_ok_reg <= 1'b1;
      if (din_fire)    blk_reg <= din_data_i;
      if (dout_fire)   dout_valid_reg <= 1'b0;
      if (blk_out_fire) begin
        dout_reg       <= core_state_i;
        dout_valid_reg <= 1'b1;
        cnt_reg        <= cnt_reg - CNT_W'(1);
      end
      if (state_reg == DRAIN && dout_fire) begin
        done_reg <= 1'b1;
        busy_reg <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_aes_cipher_core_ctrl.sv
// Bench for aes_cipher_core_ctrl: a behavioural cipher-core stub with random
// latency sits on the core side; commands are issued from tasks and every
// returned block is compared against a reference cipher function.
module tb_aes_cipher_core_ctrl;
  localparam int CNT_W = 16;
  localparam logic [255:0] FIPS_KEY =
    256'h1f1e1d1c1b1a191817161514131211100f0e0d0c0b0a09080706050403020100;
  localparam logic [127:0] FIPS_PT = 128'hffeeddccbbaa99887766554433221100;
  localparam logic [127:0] FIPS_CT = 128'h8960494b9049fceabf456751cab7a28e;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic             cmd_valid = 0, cmd_ready, cmd_decrypt = 0;
  logic [255:0]     cmd_key = '0;
  logic [CNT_W-1:0] cmd_nblocks = '0;
  logic             din_valid = 0, din_ready;
  logic [127:0]     din_data = '0;
  logic             dout_valid, dout_ready = 0;
  logic [127:0]     dout_data;
  logic             busy, done, err;
  logic             core_in_valid, core_in_ready, core_out_valid, core_out_ready;
  logic [1:0]       core_op;
  logic [2:0]       core_key_len;
  logic             core_crypt, core_dec_key_gen, core_prng_reseed;
  logic [127:0]     core_state_init, core_state;
  logic [255:0]     core_key_init;
  logic             core_alert = 0;

  aes_cipher_core_ctrl #(.CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_decrypt_i(cmd_decrypt),
    .cmd_key_i(cmd_key), .cmd_nblocks_i(cmd_nblocks),
    .din_valid_i(din_valid), .din_ready_o(din_ready), .din_data_i(din_data),
    .dout_valid_o(dout_valid), .dout_ready_i(dout_ready), .dout_data_o(dout_data),
    .busy_o(busy), .done_o(done), .err_o(err),
    .core_in_valid_o(core_in_valid), .core_in_ready_i(core_in_ready),
    .core_out_valid_i(core_out_valid), .core_out_ready_o(core_out_ready),
    .core_op_o(core_op), .core_key_len_o(core_key_len), .core_crypt_o(core_crypt),
    .core_dec_key_gen_o(core_dec_key_gen), .core_prng_reseed_o(core_prng_reseed),
    .core_state_init_o(core_state_init), .core_key_init_o(core_key_init),
    .core_state_i(core_state), .core_alert_i(core_alert)
  );

  int errors = 0;
  int checks = 0;

  // Reference cipher: FIPS-197 C.3 pair plus an invertible stand-in for other data
  function automatic logic [127:0] cipher_model(input bit dec, input logic [255:0] key,
                                                input logic [127:0] blk);
    logic [127:0] k;
    k = key[127:0] ^ key[255:128];
    if (key == FIPS_KEY && !dec && blk == FIPS_PT) return FIPS_CT;
    if (key == FIPS_KEY && dec && blk == FIPS_CT) return FIPS_PT;
    return dec ? blk - k : blk + k;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [255:0] rand256();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- cipher-core stub ----------------
  int           keygen_reqs = 0, data_reqs = 0, core_viol = 0;
  bit           stub_freeze = 0;
  bit           exp_dir = 0;
  logic [255:0] exp_key = '0;
  logic         stub_busy, rdy_rnd, pend_kg, kg_done, pv, p_kg;
  logic [255:0] pend_key, kg_key;
  logic [127:0] stub_res, p_state;
  logic [1:0]   p_op;
  int           stub_dly;

  assign core_in_ready = !stub_busy && rdy_rnd;
  assign core_state    = stub_res;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stub_busy <= 0; rdy_rnd <= 0; pend_kg <= 0; kg_done <= 0; pv <= 0;
      core_out_valid <= 0; stub_res <= '0; stub_dly <= 0;
    end else begin
      rdy_rnd <= ($urandom_range(0, 3) != 0);
      pv      <= core_in_valid && !core_in_ready;
      p_state <= core_state_init;
      p_op    <= core_op;
      p_kg    <= core_dec_key_gen;
      if (pv && !core_alert && (!core_in_valid || core_state_init !== p_state ||
                                core_op !== p_op || core_dec_key_gen !== p_kg))
        core_viol <= core_viol + 1;
      if (core_in_valid && core_in_ready) begin
        stub_busy <= 1;
        stub_dly  <= $urandom_range(0, 3);
        if (core_dec_key_gen) begin
          keygen_reqs <= keygen_reqs + 1;
          pend_kg     <= 1;
          pend_key    <= core_key_init;
          stub_res    <= rand128();
          if (core_op !== 2'b01 || core_crypt !== 1'b0) core_viol <= core_viol + 1;
        end else begin
          data_reqs <= data_reqs + 1;
          pend_kg   <= 0;
          stub_res  <= cipher_model(core_op == 2'b10, core_key_init, core_state_init);
          if (core_crypt !== 1'b1 || core_op !== (exp_dir ? 2'b10 : 2'b01) ||
              core_key_init !== exp_key || core_key_len !== 3'b100 ||
              (exp_dir && !(kg_done && kg_key == core_key_init)))
            core_viol <= core_viol + 1;
        end
      end else if (stub_busy && !core_out_valid && !stub_freeze) begin
        if (stub_dly == 0) core_out_valid <= 1;
        else               stub_dly <= stub_dly - 1;
      end
      if (core_out_valid && core_out_ready) begin
        core_out_valid <= 0;
        stub_busy      <= 0;
        if (pend_kg) begin kg_done <= 1; kg_key <= pend_key; end
      end
    end
  end

  // Model of the decryption-key cache
  bit           mk_valid = 0;
  logic [255:0] mk = '0;

  // Issue one command and stream all its blocks, checking results and status
  task automatic run_cmd(input string name, input bit dec, input logic [255:0] key,
                         input int n, input int stall, input bit rnd_ready, input bit fips);
    logic [127:0] blks[$];
    logic [127:0] exps[$];
    logic [127:0] held;
    bit   need, holding;
    int   t, cyc, sent, recv, done_cnt, done_cyc, last_cyc, kg0, dr0, viol0, full_viol, stab_viol;
    need = dec && !(mk_valid && mk == key);
    if (key != mk) mk_valid = 0;
    mk = key;
    for (int i = 0; i < n; i++) begin
      blks.push_back(fips ? (dec ? FIPS_CT : FIPS_PT) : rand128());
      exps.push_back(cipher_model(dec, key, blks[i]));
    end
    exp_dir = dec; exp_key = key;
    kg0 = keygen_reqs; dr0 = data_reqs; viol0 = core_viol;
    full_viol = 0; stab_viol = 0; holding = 0; held = '0;
    @(negedge clk);
    cmd_valid = 1; cmd_decrypt = dec; cmd_key = key; cmd_nblocks = CNT_W'(n);
    t = 0;
    while (!cmd_ready && t < 200) begin @(negedge clk); t++; end
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++; $display("FAIL %s cmd_accept: cmd_ready=%b want 1", name, cmd_ready);
    end
    @(posedge clk); #1;
    cmd_valid = 0;
    cyc = 0; sent = 0; recv = 0; done_cnt = 0; done_cyc = -1; last_cyc = 0;
    while (cyc < 3000 && !(recv >= n && cyc >= last_cyc + 3)) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1 && n > 0) begin
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL %s busy_on: busy=%b want 1", name, busy); end
      end
      din_valid = (sent < n);
      if (sent < n) din_data = blks[sent];
      dout_ready = (cyc > stall) && (rnd_ready ? ($urandom_range(0, 1) == 1) : 1'b1);
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (dout_valid && core_out_ready) full_viol++;
      if (holding && (!dout_valid || dout_data !== held)) stab_viol++;
      holding = dout_valid && !dout_ready;
      held    = dout_data;
      if (din_valid && din_ready) sent++;
      if (dout_valid && dout_ready) begin
        checks++;
        if (recv >= n) begin
          errors++; $display("FAIL %s extra_dout: got %h after %0d blocks", name, dout_data, n);
        end else if (dout_data !== exps[recv]) begin
          errors++; $display("FAIL %s dout[%0d]: got %h want %h", name, recv, dout_data, exps[recv]);
        end
        recv++;
        last_cyc = cyc;
      end
      @(posedge clk);
    end
    din_valid = 0;
    @(negedge clk);
    checks++;
    if (recv != n) begin errors++; $display("FAIL %s block_count: got %0d want %0d", name, recv, n); end
    checks++;
    if (done_cnt != 1 || done_cyc != last_cyc + 1) begin
      errors++; $display("FAIL %s done: pulses=%0d at cycle %0d want 1 at %0d", name, done_cnt, done_cyc, last_cyc + 1);
    end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL %s busy_off: busy=%b want 0", name, busy); end
    checks++;
    if (keygen_reqs - kg0 != int'(need && n > 0)) begin
      errors++; $display("FAIL %s keygen_reqs: got %0d want %0d", name, keygen_reqs - kg0, int'(need && n > 0));
    end
    checks++;
    if (data_reqs - dr0 != n) begin
      errors++; $display("FAIL %s data_reqs: got %0d want %0d", name, data_reqs - dr0, n);
    end
    checks++;
    if (core_viol != viol0 || full_viol != 0 || stab_viol != 0) begin
      errors++; $display("FAIL %s protocol: core=%0d full=%0d stab=%0d want 0", name, core_viol - viol0, full_viol, stab_viol);
    end
    if (need && n > 0) mk_valid = 1;
    $display("cmd %s dec=%0d n=%0d outputs=%0d keygens=%0d", name, dec, n, recv, keygen_reqs - kg0);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    checks++;
    if ({cmd_ready, busy, done, err, dout_valid, din_ready, core_in_valid, core_out_ready,
         core_crypt, core_dec_key_gen, core_prng_reseed} !== 11'b100_0000_0000) begin
      errors++; $display("FAIL reset_ctrl: got %b want 10000000000", {cmd_ready, busy, done, err,
        dout_valid, din_ready, core_in_valid, core_out_ready, core_crypt, core_dec_key_gen, core_prng_reseed});
    end
    checks++;
    if (core_op !== 2'b01) begin errors++; $display("FAIL reset_op: got %b want 01", core_op); end
    checks++;
    if (core_key_len !== 3'b100) begin errors++; $display("FAIL reset_keylen: got %b want 100", core_key_len); end
    checks++;
    if (core_key_init !== '0) begin errors++; $display("FAIL reset_key: got %h want 0", core_key_init); end
    $display("reset checked");
  endtask

  task automatic test_fips();
    run_cmd("fips_enc", 0, FIPS_KEY, 1, 0, 0, 1);
    run_cmd("fips_dec", 1, FIPS_KEY, 1, 0, 0, 1);
  endtask

  task automatic test_key_cache();
    run_cmd("dec_cached", 1, FIPS_KEY, 3, 0, 1, 0);
    run_cmd("dec_newkey", 1, rand256(), 2, 0, 1, 0);
  endtask

  task automatic test_zero_blocks();
    run_cmd("zero_blocks", 1, rand256(), 0, 0, 0, 0);
  endtask

  task automatic test_backpressure();
    run_cmd("backpressure", 0, rand256(), 2, 50, 0, 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++) begin
      logic [255:0] k;
      k = ($urandom_range(0, 1) == 1) ? mk : rand256();
      run_cmd("random", $urandom_range(0, 1) == 1, k, $urandom_range(1, 4), $urandom_range(0, 3), 1, 0);
    end
  endtask

  task automatic test_alert();
    int t, act;
    stub_freeze = 1;
    exp_dir = 0; exp_key = rand256();
    @(negedge clk);
    cmd_valid = 1; cmd_decrypt = 0; cmd_key = exp_key; cmd_nblocks = CNT_W'(2);
    t = 0;
    while (!cmd_ready && t < 200) begin @(negedge clk); t++; end
    @(posedge clk); #1;
    cmd_valid = 0; din_valid = 1; din_data = rand128();
    t = 0;
    while (!stub_busy && t < 200) begin @(negedge clk); t++; end
    checks++;
    if (stub_busy !== 1'b1) begin errors++; $display("FAIL alert_setup: core request seen=%b want 1", stub_busy); end
    core_alert = 1;
    @(negedge clk);
    core_alert = 0;
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL alert_err: err=%b want 1", err); end
    checks++;
    if ({core_in_valid, core_out_ready, din_ready, dout_valid, cmd_ready, done} !== 6'b0) begin
      errors++; $display("FAIL alert_quiet: got %b want 000000",
        {core_in_valid, core_out_ready, din_ready, dout_valid, cmd_ready, done});
    end
    cmd_valid = 1; act = 0;
    repeat (10) begin
      @(negedge clk);
      if (cmd_ready || core_in_valid || din_ready || dout_valid || core_out_ready || !err) act++;
    end
    checks++;
    if (act != 0) begin errors++; $display("FAIL alert_sticky: active cycles=%0d want 0", act); end
    cmd_valid = 0; din_valid = 0;
    rst_n = 0;
    repeat (3) @(negedge clk);
    rst_n = 1; stub_freeze = 0; mk_valid = 0; mk = '0;
    @(negedge clk);
    checks++;
    if (err !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++; $display("FAIL alert_reset: err=%b cmd_ready=%b want 0 1", err, cmd_ready);
    end
    $display("alert checked");
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_fips();
    test_key_cache();
    test_zero_blocks();
    test_backpressure();
    test_random();
    test_alert();
    run_cmd("post_reset_dec", 1, FIPS_KEY, 1, 0, 0, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
